// File: rtl/dpe_mux_rr_if.sv
// dpe_mux_rr_if: AXI-Stream bundle for the DPE ingress multiplexer.
// Carries the NUM_PORTS packed ingress streams and the single merged stream.
// master = traffic side (drives ingress streams, sinks the merged stream);
// slave  = the multiplexer itself.
interface dpe_mux_rr_if #(
  parameter int NUM_PORTS = 5,
  parameter int DATA_W    = 64,
  parameter int KEEP_W    = DATA_W / 8,
  parameter int ADDR_W    = 3
);
  logic [NUM_PORTS-1:0]        s_tvalid;
  logic [NUM_PORTS-1:0]        s_tready;
  logic [NUM_PORTS*DATA_W-1:0] s_tdata;
  logic [NUM_PORTS*KEEP_W-1:0] s_tkeep;
  logic [NUM_PORTS-1:0]        s_tlast;
  logic [NUM_PORTS-1:0]        s_tuser_bypass_all;
  logic [NUM_PORTS-1:0]        s_tuser_bypass_stage;
  logic [NUM_PORTS*ADDR_W-1:0] s_tuser_dst;

  logic                        m_tvalid;
  logic                        m_tready;
  logic [DATA_W-1:0]           m_tdata;
  logic [KEEP_W-1:0]           m_tkeep;
  logic                        m_tlast;
  logic                        m_tuser_bypass_all;
  logic                        m_tuser_bypass_stage;
  logic [ADDR_W-1:0]           m_tuser_src;
  logic [ADDR_W-1:0]           m_tuser_dst;

  modport master (
    output s_tvalid, s_tdata, s_tkeep, s_tlast,
           s_tuser_bypass_all, s_tuser_bypass_stage, s_tuser_dst,
    input  s_tready,
    input  m_tvalid, m_tdata, m_tkeep, m_tlast,
           m_tuser_bypass_all, m_tuser_bypass_stage, m_tuser_src, m_tuser_dst,
    output m_tready
  );

  modport slave (
    input  s_tvalid, s_tdata, s_tkeep, s_tlast,
           s_tuser_bypass_all, s_tuser_bypass_stage, s_tuser_dst,
    output s_tready,
    output m_tvalid, m_tdata, m_tkeep, m_tlast,
           m_tuser_bypass_all, m_tuser_bypass_stage, m_tuser_src, m_tuser_dst,
    input  m_tready
  );
endinterface

// File: rtl/dpe_mux_rr.sv
// dpe_mux_rr: packet-atomic round-robin AXI-Stream multiplexer at the DPE ingress.
// Port 0 is the CPU, the rest are Ethernet ports. Each packet is stamped with
// SRC_MAP[port] as its source address. Arbitration happens only at packet
// boundaries (one ARB cycle per packet, idle ports skipped in that same cycle),
// and the merged stream leaves through a 2-entry registered skid buffer.
// Optional macro DPE_MUX_PKT_CNT_EN adds per-port saturating packet counters
// (pkt_cnt / pkt_cnt_clr).
module dpe_mux_rr #(
  parameter int NUM_PORTS = 5,
  parameter int DATA_W    = 64,
  parameter int KEEP_W    = DATA_W / 8,
  parameter int ADDR_W    = 3,
  parameter logic [NUM_PORTS*ADDR_W-1:0] SRC_MAP = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pause,
  input  logic [NUM_PORTS-1:0]         port_en,
  output logic                         is_idle,
  output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
  dpe_mux_rr_if.slave                  bus
`ifdef DPE_MUX_PKT_CNT_EN
  ,
  input  logic                         pkt_cnt_clr,
  output logic [NUM_PORTS*16-1:0]      pkt_cnt
`endif
);

  localparam int GW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, XFER = 2'd2} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic              bypass_all;
    logic              bypass_stage;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
  } beat_t;

  logic [1:0]           rst_sq;
  logic                 rst_i;
  state_t               state, state_nx;
  logic [GW-1:0]        rr_ptr, rr_nx, grant_nx, pick;
  logic                 pick_vld;
  logic [NUM_PORTS-1:0] req;
  logic                 rdy_p0, xfer_p0;
  beat_t                in_beat_p0;
  beat_t                out_p1, skid_p1;
  logic                 vld_p1, skid_vld_p1;

  // Reset asserts immediately and releases two clocks later, in sync with clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sq <= 2'b11;
    else     rst_sq <= {rst_sq[0], 1'b0};
  end
  assign rst_i = rst_sq[1];

  assign req = bus.s_tvalid & port_en;

  // Round-robin pick: first requesting port at or after rr_ptr, modulo NUM_PORTS.
  always_comb begin
    logic [GW-1:0] idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = GW'((int'(rr_ptr) + k) % NUM_PORTS);
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  // Next-state logic; a granted packet always runs to its tlast.
  always_comb begin
    state_nx = state;
    grant_nx = grant_idx;
    rr_nx    = rr_ptr;
    case (state)
      IDLE: if (!pause) state_nx = ARB;
      ARB: begin
        if (pause) begin
          state_nx = IDLE;
        end else if (pick_vld) begin
          grant_nx = pick;
          state_nx = XFER;
        end
      end
      XFER: begin
        if (xfer_p0 && in_beat_p0.last) begin
          rr_nx    = (grant_idx == GW'(NUM_PORTS - 1)) ? '0 : grant_idx + GW'(1);
          state_nx = pause ? IDLE : ARB;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Arbiter state, round-robin pointer and granted port.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_nx;
      grant_idx <= grant_nx;
    end
  end

  // Stage p0: granted port's beat, stamped with its source address.
  always_comb begin
    in_beat_p0.data         = bus.s_tdata[grant_idx*DATA_W +: DATA_W];
    in_beat_p0.keep         = bus.s_tkeep[grant_idx*KEEP_W +: KEEP_W];
    in_beat_p0.last         = bus.s_tlast[grant_idx];
    in_beat_p0.bypass_all   = bus.s_tuser_bypass_all[grant_idx];
    in_beat_p0.bypass_stage = bus.s_tuser_bypass_stage[grant_idx];
    in_beat_p0.src          = SRC_MAP[grant_idx*ADDR_W +: ADDR_W];
    in_beat_p0.dst          = bus.s_tuser_dst[grant_idx*ADDR_W +: ADDR_W];
  end

  // Ready depends only on the registered skid occupancy, never on m_tready.
  assign rdy_p0  = (state == XFER) && !skid_vld_p1;
  assign xfer_p0 = rdy_p0 && bus.s_tvalid[grant_idx];

  // Only the granted port sees ready.
  always_comb begin
    bus.s_tready = '0;
    if (rdy_p0) bus.s_tready[grant_idx] = 1'b1;
  end

  // Stage p1: output/skid occupancy. Skid fills only while the output stalls.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (!vld_p1 || bus.m_tready) begin
      vld_p1      <= skid_vld_p1 || xfer_p0;
      skid_vld_p1 <= 1'b0;
    end else if (xfer_p0) begin
      skid_vld_p1 <= 1'b1;
    end
  end

  // Output register: drained from the skid first, otherwise from the input.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      out_p1 <= '0;
    end else if (!vld_p1 || bus.m_tready) begin
      if (skid_vld_p1)  out_p1 <= skid_p1;
      else if (xfer_p0) out_p1 <= in_beat_p0;
    end
  end

  // Skid entry captures the beat accepted while the output is stalled.
  always_ff @(posedge clk) begin
    if (vld_p1 && !bus.m_tready && xfer_p0) skid_p1 <= in_beat_p0;
  end

  assign bus.m_tvalid             = vld_p1;
  assign bus.m_tdata              = out_p1.data;
  assign bus.m_tkeep              = out_p1.keep;
  assign bus.m_tlast              = out_p1.last;
  assign bus.m_tuser_bypass_all   = out_p1.bypass_all;
  assign bus.m_tuser_bypass_stage = out_p1.bypass_stage;
  assign bus.m_tuser_src          = out_p1.src;
  assign bus.m_tuser_dst          = out_p1.dst;

  assign is_idle = (state == IDLE) && !skid_vld_p1 && !vld_p1;

`ifdef DPE_MUX_PKT_CNT_EN
  logic [NUM_PORTS-1:0][15:0] cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Per-port packet counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (pkt_cnt_clr) begin
      cnt <= '0;
    end else if (xfer_p0 && in_beat_p0.last) begin
      cnt[grant_idx] <= sat_inc16(cnt[grant_idx]);
    end
  end

  assign pkt_cnt = cnt;
`endif

endmodule

// File: tb/tb_dpe_mux_rr.sv
// tb_dpe_mux_rr: directed bench for dpe_mux_rr (5 ports, 64-bit data, non-identity SRC_MAP).
module tb_dpe_mux_rr;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        ba;
    logic        bs;
    logic [2:0]  src;
    logic [2:0]  dst;
  } beat_t;

  logic       clk;
  logic       rst;
  logic       pause;
  logic [4:0] port_en;
  logic       is_idle;
  logic [2:0] grant_idx;
`ifdef DPE_MUX_PKT_CNT_EN
  logic        pkt_cnt_clr;
  logic [79:0] pkt_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;
  int smap [5] = '{6, 1, 5, 7, 3};

  beat_t srcq [5][$];
  beat_t log_q [$];
  int    stamp_q [$];

  dpe_mux_rr_if #(.NUM_PORTS(5), .DATA_W(64), .KEEP_W(8), .ADDR_W(3)) bus ();

  dpe_mux_rr #(
    .NUM_PORTS(5), .DATA_W(64), .KEEP_W(8), .ADDR_W(3),
    .SRC_MAP({3'd3, 3'd7, 3'd5, 3'd1, 3'd6})
  ) dut (
    .clk(clk), .rst(rst), .pause(pause), .port_en(port_en),
    .is_idle(is_idle), .grant_idx(grant_idx), .bus(bus)
`ifdef DPE_MUX_PKT_CNT_EN
    , .pkt_cnt_clr(pkt_cnt_clr), .pkt_cnt(pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n = cyc_n + 1;

  function automatic beat_t mk(input int port, input int k, input int n, input int tag);
    beat_t b;
    b.data = {8'(port), 8'(tag), 16'hA5C3, 32'(k)};
    b.keep = (k == n - 1) ? 8'h3F : 8'hFF;
    b.last = (k == n - 1);
    b.ba   = (k % 2) == 1;
    b.bs   = (port % 2) == 0;
    b.src  = 3'(smap[port]);
    b.dst  = 3'((port + tag) % 8);
    return b;
  endfunction

  task automatic enq(input int port, input int n, input int tag);
    for (int k = 0; k < n; k++) srcq[port].push_back(mk(port, k, n, tag));
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int t;
    t = 0;
    while (log_q.size() < n && t < budget) begin
      cyc();
      t++;
    end
    chk(tag, 128'(log_q.size() >= n), 128'(1));
  endtask

  function automatic beat_t cur_m();
    beat_t m;
    m.data = bus.m_tdata;
    m.keep = bus.m_tkeep;
    m.last = bus.m_tlast;
    m.ba   = bus.m_tuser_bypass_all;
    m.bs   = bus.m_tuser_bypass_stage;
    m.src  = bus.m_tuser_src;
    m.dst  = bus.m_tuser_dst;
    return m;
  endfunction

  // Source model drives ingress ports at negedge; sink/accept detection 3ns later.
  initial begin
    logic [4:0] acc;
    acc = '0;
    bus.s_tvalid = '0; bus.s_tdata = '0; bus.s_tkeep = '0; bus.s_tlast = '0;
    bus.s_tuser_bypass_all = '0; bus.s_tuser_bypass_stage = '0; bus.s_tuser_dst = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        if (srcq[i].size() > 0) begin
          bus.s_tvalid[i]                = 1'b1;
          bus.s_tdata[i*64 +: 64]        = srcq[i][0].data;
          bus.s_tkeep[i*8 +: 8]          = srcq[i][0].keep;
          bus.s_tlast[i]                 = srcq[i][0].last;
          bus.s_tuser_bypass_all[i]      = srcq[i][0].ba;
          bus.s_tuser_bypass_stage[i]    = srcq[i][0].bs;
          bus.s_tuser_dst[i*3 +: 3]      = srcq[i][0].dst;
        end else begin
          bus.s_tvalid[i] = 1'b0;
        end
      end
      #3;
      for (int i = 0; i < 5; i++) acc[i] = bus.s_tvalid[i] & bus.s_tready[i];
      if (bus.m_tvalid && bus.m_tready) begin
        log_q.push_back(cur_m());
        stamp_q.push_back(cyc_n);
      end
    end
  end

  initial begin
    int    base;
    int    accepted;
    beat_t snap;
    int    ord_p [8];
    int    ord_t [8];

    rst = 1'b1; pause = 1'b0; port_en = 5'h1F; bus.m_tready = 1'b1;
`ifdef DPE_MUX_PKT_CNT_EN
    pkt_cnt_clr = 1'b0;
`endif
    repeat (3) cyc();

    // Reset state
    chk("rst_is_idle",  128'(is_idle), 128'(1));
    chk("rst_m_tvalid", 128'(bus.m_tvalid), 128'(0));
    chk("rst_s_tready", 128'(bus.s_tready), 128'(0));
    chk("rst_grant",    128'(grant_idx), 128'(0));
    chk("rst_m_tdata",  128'(bus.m_tdata), 128'(0));
    chk("rst_m_src",    128'(bus.m_tuser_src), 128'(0));
    chk("rst_m_tlast",  128'(bus.m_tlast), 128'(0));

    pause = 1'b1;
    rst   = 1'b0;
    repeat (4) cyc();
    chk("paused_idle", 128'(is_idle), 128'(1));

    // Test 1: ports 0,2,4 each 3 beats; order 0,2,4, one ARB cycle between packets
    enq(0, 3, 1); enq(2, 3, 1); enq(4, 3, 1);
    cyc();
    base  = log_q.size();
    pause = 1'b0;
    wait_log(base + 9, 60, "t1_count");
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 3; k++)
        chk($sformatf("t1_beat_p%0d_k%0d", 2 * p, k), 128'(log_q[base + 3*p + k]), 128'(mk(2 * p, k, 3, 1)));
    chk("t1_contig",   128'(stamp_q[base + 1] - stamp_q[base]), 128'(1));
    chk("t1_gap_0_2",  128'(stamp_q[base + 3] - stamp_q[base + 2]), 128'(2));
    chk("t1_gap_2_4",  128'(stamp_q[base + 6] - stamp_q[base + 5]), 128'(2));
    chk("t1_grant",    128'(grant_idx), 128'(4));

    // Test 2: port 1 4-beat packet, pause mid-packet
    base = log_q.size();
    enq(1, 4, 2);
    wait_log(base + 1, 20, "t2_start");
    pause = 1'b1;
    wait_log(base + 4, 20, "t2_count");
    chk("t2_is_idle", 128'(is_idle), 128'(1));
    for (int k = 0; k < 4; k++)
      chk($sformatf("t2_beat_k%0d", k), 128'(log_q[base + k]), 128'(mk(1, k, 4, 2)));
    enq(3, 6, 3);
    repeat (4) cyc();
    chk("t2_no_ready", 128'(bus.s_tready), 128'(0));
    chk("t2_no_beats", 128'(log_q.size()), 128'(base + 4));
    chk("t2_still_idle", 128'(is_idle), 128'(1));

    // Test 3: port 3 6-beat packet with a 5-cycle m_tready stall
    base  = log_q.size();
    pause = 1'b0;
    wait_log(base + 2, 20, "t3_start");
    bus.m_tready = 1'b0;
    snap = cur_m();
    repeat (5) cyc();
    accepted = 6 - srcq[3].size();
    chk("t3_buffered", 128'(accepted - (log_q.size() - base)), 128'(2));
    chk("t3_ready_low", 128'(bus.s_tready[3]), 128'(0));
    chk("t3_m_tvalid", 128'(bus.m_tvalid), 128'(1));
    chk("t3_stable", 128'(cur_m()), 128'(snap));
    bus.m_tready = 1'b1;
    wait_log(base + 6, 30, "t3_count");
    for (int k = 0; k < 6; k++)
      chk($sformatf("t3_beat_k%0d", k), 128'(log_q[base + k]), 128'(mk(3, k, 6, 3)));
    repeat (2) cyc();
    chk("t3_no_dup", 128'(log_q.size()), 128'(base + 6));

    // Test 5: back-to-back single-beat packets on port 4, 2 clk each
    base = log_q.size();
    enq(4, 1, 5); enq(4, 1, 6); enq(4, 1, 7);
    wait_log(base + 3, 30, "t5_count");
    for (int j = 0; j < 3; j++)
      chk($sformatf("t5_beat_%0d", j), 128'(log_q[base + j]), 128'(mk(4, 0, 1, 5 + j)));
    chk("t5_rate_a", 128'(stamp_q[base + 1] - stamp_q[base]), 128'(2));
    chk("t5_rate_b", 128'(stamp_q[base + 2] - stamp_q[base + 1]), 128'(2));

    // Test 4: port 1 masked, all ports valid; grants 0,2,3,4,0,2,3,4
    base    = log_q.size();
    port_en = 5'b11101;
    for (int p = 0; p < 5; p++) enq(p, 1, 8);
    for (int p = 0; p < 5; p++) enq(p, 1, 9);
    wait_log(base + 8, 60, "t4_count");
    ord_p = '{0, 2, 3, 4, 0, 2, 3, 4};
    ord_t = '{8, 8, 8, 8, 9, 9, 9, 9};
    for (int j = 0; j < 8; j++)
      chk($sformatf("t4_grant_%0d", j), 128'(log_q[base + j]), 128'(mk(ord_p[j], 0, 1, ord_t[j])));
    chk("t4_port1_held", 128'(srcq[1].size()), 128'(2));
    pause = 1'b1;
    repeat (3) cyc();
    srcq[1].delete();
    repeat (2) cyc();
    port_en = 5'h1F;
    cyc();
    chk("t4_idle", 128'(is_idle), 128'(1));

    // Test 6: reset mid-packet, then resume from port 0
    base  = log_q.size();
    enq(2, 5, 10);
    pause = 1'b0;
    wait_log(base + 2, 30, "t6_start");
    rst = 1'b1;
    #1;
    chk("t6_m_tvalid", 128'(bus.m_tvalid), 128'(0));
    chk("t6_s_tready", 128'(bus.s_tready), 128'(0));
    chk("t6_is_idle",  128'(is_idle), 128'(1));
    for (int i = 0; i < 5; i++) srcq[i].delete();
    base = log_q.size();
    enq(3, 1, 11);
    enq(0, 1, 12);
    repeat (2) cyc();
    rst = 1'b0;
    wait_log(base + 2, 30, "t6_count");
    chk("t6_first_p0",  128'(log_q[base]),     128'(mk(0, 0, 1, 12)));
    chk("t6_second_p3", 128'(log_q[base + 1]), 128'(mk(3, 0, 1, 11)));
    repeat (2) cyc();
    chk("t6_no_extra", 128'(log_q.size()), 128'(base + 2));

`ifdef DPE_MUX_PKT_CNT_EN
    // Packet counters
    chk("cnt_p0", 128'(pkt_cnt[0*16 +: 16]), 128'(1));
    chk("cnt_p3", 128'(pkt_cnt[3*16 +: 16]), 128'(1));
    base = log_q.size();
    enq(2, 1, 13); enq(2, 1, 14); enq(2, 1, 15);
    wait_log(base + 3, 30, "cnt_traffic");
    chk("cnt_p2", 128'(pkt_cnt[2*16 +: 16]), 128'(3));
    pkt_cnt_clr = 1'b1;
    cyc();
    pkt_cnt_clr = 1'b0;
    chk("cnt_clr", 128'(pkt_cnt), 128'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpe_mux_rr.md
Name: dpe_mux_rr

Overview:
- Parametrised N-input, packet-atomic AXI-Stream multiplexer at the DPE ingress. Merges the CPU port and NUM_PORTS-1 Ethernet ports onto one DPE stream.
- Stamps each packet with a per-port source address.
- Round-robin arbitration skips idle ports in zero extra cycles. Grants are qualified by a per-port enable mask.
- Pauses only at packet boundaries. The output is registered through an internal 2-entry skid buffer.

Parameters:
- NUM_PORTS, 5, number of input ports (2..16). Port 0 is the CPU.
- DATA_W, 64, tdata width in bits (multiple of 8).
- KEEP_W, DATA_W/8, tkeep width.
- ADDR_W, 3, width of tuser_src / tuser_dst.
- SRC_MAP, {3'd4,3'd3,3'd2,3'd1,3'd0}, packed NUM_PORTS*ADDR_W. SRC_MAP[i*ADDR_W +: ADDR_W] is stamped as the source address of port i.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- pause  in  1  request to stop granting new packets
- port_en  in  NUM_PORTS  per-port grant enable
- is_idle  out  1  paused and output fully drained
- s_tvalid  in  NUM_PORTS  per-port valid
- s_tready  out  NUM_PORTS  per-port ready
- s_tdata  in  NUM_PORTS*DATA_W  packed data
- s_tkeep  in  NUM_PORTS*KEEP_W  packed keep
- s_tlast  in  NUM_PORTS  end of packet
- s_tuser_bypass_all  in  NUM_PORTS  bypass-all flag
- s_tuser_bypass_stage  in  NUM_PORTS  bypass-stage flag
- s_tuser_dst  in  NUM_PORTS*ADDR_W  destination address
- m_tvalid / m_tready / m_tdata / m_tkeep / m_tlast  out/in/out/out/out  1/1/DATA_W/KEEP_W/1  merged stream
- m_tuser_bypass_all, m_tuser_bypass_stage  out  1 each  forwarded flags
- m_tuser_src  out  ADDR_W  SRC_MAP entry of the granted port
- m_tuser_dst  out  ADDR_W  forwarded destination address
- grant_idx  out  $clog2(NUM_PORTS)  currently or last granted port (debug)

Behaviour:
- Reset (async assert, sync deassert internal):
  - state=IDLE, rr_ptr=0, grant_idx=0, skid buffer empty.
  - m_tvalid=0, all s_tready=0, is_idle=1, all m_* data/user outputs = 0.
- FSM states: IDLE, ARB, XFER.
- IDLE:
  - No grants; s_tready=0.
  - pause==0 moves to ARB next cycle.
- ARB:
  - req[i] = s_tvalid[i] & port_en[i].
  - pause==1 moves to IDLE; pause has priority over a pending request.
  - Otherwise, if any req: grant = first set req scanning rr_ptr, rr_ptr+1, … modulo NUM_PORTS. Register it to grant_idx and go to XFER.
  - No req: stay in ARB. No dead cycles per empty port.
- XFER:
  - Only s_tready[grant_idx] = skid input ready; all other s_tready=0.
  - Beat transfers when s_tvalid[g] & s_tready[g].
  - The skid input carries the granted port's data, keep, last, bypass flags and dst, with src=SRC_MAP[g].
  - On a transfer with tlast: rr_ptr = (g+1) mod NUM_PORTS (wrap at NUM_PORTS-1 to 0). Next state is IDLE if pause, else ARB.
  - pause and port_en changes mid-packet are ignored until tlast; a packet is never split or aborted.
- Arbitration costs one cycle per packet (ARB). Payload bandwidth is one beat/clk within a packet.
- Output skid buffer:
  - 2 entries, full throughput, registered m_* outputs.
  - Latency 1 clk from s_ handshake to m_tvalid.
  - Skid input ready = entry 1 empty (registered, never combinational from m_tready).
  - m_tready held low: at most 2 beats absorbed, then s_tready drops.
- is_idle = (state==IDLE) & skid buffer empty & !m_tvalid.
- Simultaneous events: pause rising in the same cycle as the tlast transfer gives IDLE with that beat delivered. The output buffer still drains while in IDLE.
- Reset mid-packet: the packet is truncated and no tlast is emitted. Downstream must also be reset.
- m_tuser_src/dst and flags are stable for the whole beat while m_tvalid & !m_tready (AXIS rule).

Optional Feature:
- DPE_MUX_PKT_CNT_EN defined:
  - Adds output pkt_cnt, NUM_PORTS*16 bits, and input pkt_cnt_clr (1 bit).
  - Per-port 16-bit saturating counter increments on each accepted tlast beat of that port.
  - Holds at 16'hFFFF.
  - pkt_cnt_clr zeroes all counters synchronously; clear wins over a same-cycle increment.
  - Counters reset to 0.
- Not defined: those ports and the counter logic are absent; the rest of the behaviour is identical.

Test Plan:
- Ports 0,2,4 each send a 3-beat packet at once, rr_ptr=0, m_tready=1 → output order src 0,2,4. Each packet is contiguous with tlast on its 3rd beat. Ports 1/3 are skipped with no idle cycle beyond ARB.
- Port 1 sends a 4-beat packet; pause rises on beat 2 → all 4 beats delivered, then IDLE. is_idle=1 one cycle after the last m_ handshake; no further s_tready.
- m_tready=0 for 5 cycles during port 3's 6-beat packet → exactly 2 beats buffered, s_tready[3]=0 thereafter. Data/user stable; no beat lost or duplicated on resume.
- port_en=5'b11101 with all ports valid → port 1 is never granted. The remaining grants rotate 0,2,3,4,0 with wrap-around.
- Single-beat packets back-to-back on port 4 only → each takes 2 clk (ARB+XFER). m_tuser_src=SRC_MAP[4], tdst forwarded unchanged.
- Assert rst mid-packet → m_tvalid=0, s_tready=0 immediately (async). Resumes at port 0 after deassert. With DPE_MUX_PKT_CNT_EN: 70000 port-2 packets → pkt_cnt[2]=16'hFFFF, and clr → 0.
